// File: rtl/sobel_window_feeder_pkg.sv
// Shared definitions for the Sobel feeder and the PE chains it drives.
//   PIX_W / ACC_W   : pixel and accumulator widths, shared with pe_sobel
//   feeder_state_e  : feeder FSM encodings
//   gx_weight/gy_weight : 3x3 Sobel kernel weights, row 0 = top, col 0 = left
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

  function automatic int gx_weight(input int row, input int col);
    int mag;
    mag = (row == 1) ? 2 : 1;
    if (col == 0) return -mag;
    if (col == 2) return mag;
    return 0;
  endfunction

  function automatic int gy_weight(input int row, input int col);
    int mag;
    mag = (col == 1) ? 2 : 1;
    if (row == 0) return -mag;
    if (row == 2) return mag;
    return 0;
  endfunction

endpackage

// File: rtl/sobel_window_feeder_if.sv
// Pixel-stream handshake plus column outputs of the Sobel feeder.
//   slave  : the feeder (consumes pixels, produces columns)
//   master : the pixel source / observer of the columns
interface sobel_window_feeder_if;
  logic                        start;
  logic                        pix_valid;
  logic [sobel_pkg::PIX_W-1:0] pix_in;
  logic                        pix_ready;
  logic                        compute_valid;
  logic [sobel_pkg::PIX_W-1:0] x_top;
  logic [sobel_pkg::PIX_W-1:0] x_mid;
  logic [sobel_pkg::PIX_W-1:0] x_bot;
  logic [9:0]                  col_idx;
  logic [9:0]                  row_idx;
  logic                        frame_done;
  logic                        busy;

  modport slave (
    input  start, pix_valid, pix_in,
    output pix_ready, compute_valid, x_top, x_mid, x_bot,
           col_idx, row_idx, frame_done, busy
  );

  modport master (
    output start, pix_valid, pix_in,
    input  pix_ready, compute_valid, x_top, x_mid, x_bot,
           col_idx, row_idx, frame_done, busy
  );
endinterface

// File: rtl/sobel_window_feeder_line_ram.sv
// One image row of pixel storage.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write column
//   wdata_i  : write pixel
//   raddr_i  : read column (asynchronous read)
//   rdata_o  : read pixel; returns the old word on a same-cycle write to the same column
module sobel_line_ram
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset: rows 0-1 of every frame refill them.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sobel_window_feeder.sv
// Sobel window feeder: takes a raster pixel stream, keeps the two previous rows in
// line buffers and emits one 3-row column per accepted pixel from row 2 onward.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pixel handshake in, column/status outputs (sobel_window_feeder_if.slave)
module sobel_window_feeder
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sobel_window_feeder_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] FIRST_OUT = RW'(2);

  feeder_state_e    state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             ready, accept, emit;
  logic [PIX_W-1:0] lba_rd, lbb_rd;

  logic             cv_q;
  logic [PIX_W-1:0] top_q, mid_q, bot_q;
  logic [CW-1:0]    col_idx_q;
  logic [RW-1:0]    row_idx_q;

  assign ready  = (state_q == ST_RUN);
  assign accept = bus.pix_valid & ready;
  assign emit   = accept & (row_q >= FIRST_OUT);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_RUN;
        col_d   = '0;
        row_d   = '0;
      end
      ST_RUN: if (accept) begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + 1'b1;
          if (row_q == LAST_ROW) state_d = ST_DONE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cv_q      <= 1'b0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      col_idx_q <= '0;
      row_idx_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cv_q    <= emit;
      top_q   <= emit ? lbb_rd     : '0;
      mid_q   <= emit ? lba_rd     : '0;
      bot_q   <= emit ? bus.pix_in : '0;
      if (accept) begin
        col_idx_q <= col_q;
        row_idx_q <= row_q;
      end
    end
  end

  // lbA holds row r-1, lbB row r-2; the shift relies on read-before-write at column c.
  sobel_line_ram #(.DEPTH(IMG_W), .AW(CW)) u_lba (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (bus.pix_in),
    .raddr_i (col_q),
    .rdata_o (lba_rd)
  );

  sobel_line_ram #(.DEPTH(IMG_W), .AW(CW)) u_lbb (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (lba_rd),
    .raddr_i (col_q),
    .rdata_o (lbb_rd)
  );

  assign bus.pix_ready     = ready;
  assign bus.compute_valid = cv_q;
  assign bus.x_top         = top_q;
  assign bus.x_mid         = mid_q;
  assign bus.x_bot         = bot_q;
  assign bus.col_idx       = 10'(col_idx_q);
  assign bus.row_idx       = 10'(row_idx_q);
  assign bus.frame_done    = (state_q == ST_DONE);
  assign bus.busy          = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule
